fir_tap_sequencer: RTL
======================

Name: fir_tap_sequencer

Overview:
Sequences a serial N-tap FIR filter built around one shared sign-magnitude multiplier.
- Loads N_TAPS signed coefficients over the same input bus that later carries samples.
- Keeps a sample delay line and runs one multiply-accumulate per cycle across all taps.
- Emits one saturated output per accepted sample.
- Sits between the pin-level input bus and the output pins of the FIR top level.

Parameters:
N_TAPS, 4, number of taps / coefficients (>=1)
BW_in, 6, signed width of coefficients and samples
BW_product, 12, signed width of one product
BW_acc, 14, signed accumulator width (BW_product + clog2(N_TAPS))
BW_out, 8, signed output width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
load_start  input  1  in IDLE: request a coefficient reload
in_valid  input  1  x_in carries a coefficient or sample
in_ready  output  1  block accepts x_in this cycle (transfer = in_valid & in_ready)
x_in  input  BW_in  signed two's-complement coefficient or sample
y_out  output  BW_out  signed filter output, held between updates
out_valid  output  1  one-cycle pulse: y_out is new
busy  output  1  high in MAC and DONE

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- reset_n is asynchronous and active-low.

Reset values (asynchronous, reset_n=0):
- State LOAD, coefficient index 0.
- All coefficients, delay line and accumulator = 0.
- y_out=0, out_valid=0, busy=0.
- Reset asserted at any point, including mid-MAC, aborts immediately. Coefficients must then be reloaded.

States:
- LOAD:
  - in_ready=1. Each transfer writes coef[idx] <= x_in and increments idx.
  - After the transfer with idx=N_TAPS-1, go to IDLE.
  - The delay line is cleared on entry to LOAD.
- IDLE:
  - in_ready = !load_start.
  - load_start=1: go to LOAD, idx=0, clear the delay line. load_start has priority, so no sample is accepted that cycle.
  - Otherwise a transfer shifts the delay line (d[0]<=x_in, d[k]<=d[k-1]), sets tap=0 and acc=0, and goes to MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc <= acc + d[tap]*coef[tap]; tap++.
  - After the tap=N_TAPS-1 cycle, go to DONE.
  - load_start is ignored.
- DONE:
  - in_ready=0, out_valid=1 for exactly this cycle.
  - y_out is registered on entry to DONE.
  - Next cycle goes to IDLE.

Timing:
- Sample accepted at cycle T → out_valid at T+N_TAPS+1.
- Next sample can be accepted at T+N_TAPS+2, giving a throughput of 1 sample per N_TAPS+2 cycles.

Arithmetic:
- Multiplier is sign-magnitude, matching the existing datapath.
  - Magnitudes |a|, |b| are unsigned (|-32|=32 fits BW_in bits unsigned).
  - Product sign = sign(a) XOR sign(b).
  - Result is negated to two's complement in BW_product bits.
- Worst-case product magnitude is 1024, so no product overflow.
- acc is sign-extended to BW_acc bits and cannot overflow.
- y_out saturates acc to [-2^(BW_out-1), 2^(BW_out-1)-1]. No truncation wrap.

Boundary conditions:
- N_TAPS=1: MAC lasts one cycle.
- in_valid=0 in LOAD or IDLE: state and data are held.
- Coefficients persist across any number of samples until load_start or reset.

Decomposition:
Package fir_pkg:
- State encoding: LOAD, IDLE, MAC, DONE.
- Tap-index width constant: clog2(N_TAPS), minimum 1.
- Saturation limit constants.

Sub-module fir_sm_multiplier:
- Combinational sign-magnitude BW_in × BW_in → BW_product signed.
- Instantiated once and shared across taps.

Test Plan:
1. Coefficients 1,0,0,0; samples 5, -3 → y_out 5, -3; each out_valid exactly N_TAPS+1 cycles after acceptance.
2. Coefficients 1,2,3,4; samples 1,0,0,0,0 → y_out 1,2,3,4,0.
3. Saturation, coefficients -32 ×4:
   - Samples -32 ×4 → 4th output acc=4096 → y_out=127.
   - Then reload coefficients 31 ×4; samples -32 ×4 → 4th acc=-3968 → y_out=-128.
4. in_valid held high continuously with distinct samples:
   - in_ready low during MAC and DONE.
   - One transfer every 6 cycles (N_TAPS=4), no sample lost or duplicated.
5. reset_n pulsed low during the 2nd MAC cycle:
   - Outputs clear asynchronously: y_out=0, out_valid=0, busy=0.
   - After release, in_ready=1 in LOAD.
   - After 4 coefficient loads, 1st sample output reflects an all-zero history.
6. load_start=1 and in_valid=1 together in IDLE:
   - in_ready=0 and the sample is not accepted; block enters LOAD with delay line cleared.
   - New coefficients 2,0,0,0 then sample 7 → y_out 14.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg - state encoding and sizing helpers shared by the FIR tap sequencer
// Revision: 1.0
// ============================================================================
package fir_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_LOAD = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd1;
    localparam logic [STATE_W-1:0] ST_MAC  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    // Tap/coefficient index width; a single-tap filter still needs one bit.
    function automatic int tap_idx_w(input int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

    function automatic int sat_hi(input int bw_out);
        return (1 << (bw_out - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int bw_out);
        return -(1 << (bw_out - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sm_multiplier.sv
`default_nettype none
// ============================================================================
// fir_sm_multiplier - combinational sign-magnitude signed multiplier
// Revision: 1.0
// ============================================================================
module fir_sm_multiplier #(
    parameter int BW_in      = 6,
    parameter int BW_product = 12
) (
    input  logic signed [BW_in-1:0]      a,
    input  logic signed [BW_in-1:0]      b,
    output logic signed [BW_product-1:0] p
);

    logic [BW_in-1:0]      mag_a;
    logic [BW_in-1:0]      mag_b;
    logic [BW_product-1:0] mag_p;
    logic                  neg;

    // The most negative input maps to its unsigned magnitude (e.g. -32 -> 32).
    assign mag_a = a[BW_in-1] ? BW_in'(-a) : BW_in'(a);
    assign mag_b = b[BW_in-1] ? BW_in'(-b) : BW_in'(b);
    assign mag_p = BW_product'(mag_a) * BW_product'(mag_b);
    assign neg   = a[BW_in-1] ^ b[BW_in-1];
    assign p     = neg ? (~mag_p + BW_product'(1)) : mag_p;

endmodule
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// fir_tap_sequencer - coefficient load, delay line and serial MAC sequencing
// Revision: 1.0
// ============================================================================
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int N_TAPS     = 4,
    parameter int BW_in      = 6,
    parameter int BW_product = 12,
    parameter int BW_acc     = 14,
    parameter int BW_out     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [BW_in-1:0]  x_in,
    output logic signed [BW_out-1:0] y_out,
    output logic                     out_valid,
    output logic                     busy
);

    localparam int                       TAP_W    = tap_idx_w(N_TAPS);
    localparam logic [TAP_W-1:0]         LAST_TAP = TAP_W'(N_TAPS - 1);
    localparam logic signed [BW_acc-1:0] ACC_HI   = BW_acc'(sat_hi(BW_out));
    localparam logic signed [BW_acc-1:0] ACC_LO   = BW_acc'(sat_lo(BW_out));

    logic [STATE_W-1:0]        state;
    logic [STATE_W-1:0]        state_nxt;
    logic [TAP_W-1:0]          idx;
    logic signed [BW_in-1:0]   coef [N_TAPS];
    logic signed [BW_in-1:0]   dly  [N_TAPS];
    logic signed [BW_acc-1:0]  acc;
    logic signed [BW_product-1:0] prod;
    logic signed [BW_acc-1:0]  prod_ext;
    logic signed [BW_acc-1:0]  acc_sum;
    logic signed [BW_out-1:0]  sat_val;
    logic                      xfer;
    logic                      last;

    assign xfer = in_valid & in_ready;
    assign last = (idx == LAST_TAP);

    fir_sm_multiplier #(
        .BW_in      (BW_in),
        .BW_product (BW_product)
    ) u_mul (
        .a (dly[idx]),
        .b (coef[idx]),
        .p (prod)
    );

    assign prod_ext = BW_acc'(prod);
    assign acc_sum  = acc + prod_ext;

    always_comb begin
        sat_val = acc_sum[BW_out-1:0];
        if (acc_sum > ACC_HI) begin
            sat_val = ACC_HI[BW_out-1:0];
        end else if (acc_sum < ACC_LO) begin
            sat_val = ACC_LO[BW_out-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (xfer && last) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (load_start)  state_nxt = ST_LOAD;
                else if (xfer)   state_nxt = ST_MAC;
            end
            ST_MAC:  if (last) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_LOAD: in_ready  = 1'b1;
            ST_IDLE: in_ready  = ~load_start;
            ST_MAC:  busy      = 1'b1;
            default: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
        endcase
    end

    // idx serves as the coefficient write pointer in LOAD and the tap pointer in MAC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            acc   <= '0;
            y_out <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
                coef[k] <= '0;
                dly[k]  <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (xfer) begin
                        coef[idx] <= x_in;
                        idx       <= last ? '0 : idx + TAP_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (load_start) begin
                        idx <= '0;
                        for (int k = 0; k < N_TAPS; k++) begin
                            dly[k] <= '0;
                        end
                    end else if (xfer) begin
                        dly[0] <= x_in;
                        for (int k = 1; k < N_TAPS; k++) begin
                            dly[k] <= dly[k-1];
                        end
                        idx <= '0;
                        acc <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc_sum;
                    idx <= last ? '0 : idx + TAP_W'(1);
                    if (last) begin
                        y_out <= sat_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
